split_4ph: RTL and testbench

Clocked two-way split for 4-phase bundled-data channels: the inverse of the merge stage. One data token on D is steered by a one-bit select token on S to exactly one of two output channels, O0 or O1. Forward and backward latencies are set in clock cycles, matching the FL/BL conventions of the merge. The block sits downstream of merges and routers in the token network, and feeds per-output token counts and a protocol-error flag to the debug registers.

---
 rtl/split_4ph.sv | 124 ++++++++++++
 tb/tb_split_4ph.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/split_4ph.sv
// rtl/split_4ph.sv - clocked two-way split for 4-phase bundled-data channels
module split_4ph #(
  parameter int          WIDTH      = 33,
  parameter int          FL         = 4,
  parameter int          BL         = 6,
  parameter logic [15:0] COUNT_INIT = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_req,
  output logic             d_ack,
  input  logic [WIDTH-1:0] d_data,
  input  logic             s_req,
  output logic             s_ack,
  input  logic             s_sel,
  output logic             o0_req,
  input  logic             o0_ack,
  output logic [WIDTH-1:0] o0_data,
  output logic             o1_req,
  input  logic             o1_ack,
  output logic [WIDTH-1:0] o1_data,
  output logic [15:0]      count0,
  output logic [15:0]      count1,
  output logic             proto_err
);

  typedef enum logic [2:0] {IDLE, FWD, OREQ, BWD, IACK} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] data_q, data_nx;
  logic             sel_q, sel_nx;
  logic [7:0]       cnt, cnt_nx;
  logic [15:0]      count0_q, count0_nx;
  logic [15:0]      count1_q, count1_nx;
  logic             err_q, err_nx;
  logic             sel_ack, other_ack, both_req;

  assign sel_ack   = sel_q ? o1_ack : o0_ack;
  assign other_ack = sel_q ? o0_ack : o1_ack;
  assign both_req  = d_req & s_req;

  // Handshake outputs decode straight from the state so reset clears them at once.
  assign o0_req    = (state == OREQ) & ~sel_q;
  assign o1_req    = (state == OREQ) &  sel_q;
  assign d_ack     = (state == IACK);
  assign s_ack     = (state == IACK);
  assign o0_data   = data_q;
  assign o1_data   = data_q;
  assign count0    = count0_q;
  assign count1    = count1_q;
  assign proto_err = err_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      data_q   <= '0;
      sel_q    <= 1'b0;
      cnt      <= 8'd0;
      count0_q <= COUNT_INIT;
      count1_q <= COUNT_INIT;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      data_q   <= data_nx;
      sel_q    <= sel_nx;
      cnt      <= cnt_nx;
      count0_q <= count0_nx;
      count1_q <= count1_nx;
      err_q    <= err_nx;
    end
  end

  // Next-state, capture, latency counting, token counting and error detection.
  always_comb begin
    state_nx  = state;
    data_nx   = data_q;
    sel_nx    = sel_q;
    cnt_nx    = cnt;
    count0_nx = count0_q;
    count1_nx = count1_q;
    err_nx    = err_q;
    case (state)
      IDLE: begin
        // A capture edge ignores any ack seen on the same edge.
        if (both_req) begin
          data_nx  = d_data;
          sel_nx   = s_sel;
          cnt_nx   = 8'(FL);
          state_nx = FWD;
        end else if (sel_ack) begin
          err_nx = 1'b1;
        end
      end
      FWD: begin
        cnt_nx = cnt - 8'd1;
        if (cnt == 8'd1) state_nx = OREQ;
        if (!both_req || sel_ack) err_nx = 1'b1;
      end
      OREQ: begin
        if (sel_ack) begin
          cnt_nx   = 8'(BL);
          state_nx = BWD;
        end
        if (!both_req) err_nx = 1'b1;
      end
      BWD: begin
        cnt_nx = cnt - 8'd1;
        if (cnt == 8'd1) state_nx = IACK;
        if (!both_req) err_nx = 1'b1;
      end
      IACK: begin
        if (!d_req && !s_req && !sel_ack) begin
          state_nx = IDLE;
          if (sel_q) count1_nx = count1_q + 16'd1;
          else       count0_nx = count0_q + 16'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (state != IDLE && other_ack) err_nx = 1'b1;
  end

endmodule

// File: tb/tb_split_4ph.sv
// tb/tb_split_4ph.sv - randomized self-checking bench for split_4ph
module tb_split_4ph;

  localparam int WIDTH  = 33;
  localparam int FL     = 4;
  localparam int BL     = 6;
  localparam int BUDGET = 200;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             d_req, s_req, s_sel, o0_ack, o1_ack;
  logic [WIDTH-1:0] d_data;
  logic             d_ack, s_ack, o0_req, o1_req, proto_err;
  logic [WIDTH-1:0] o0_data, o1_data;
  logic [15:0]      count0, count1;
  logic             w_d_ack, w_s_ack, w_o0_req, w_o1_req, w_err;
  logic [WIDTH-1:0] w_o0_data, w_o1_data;
  logic [15:0]      w_count0, w_count1;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [15:0] exp_cnt0 = 16'd0;
  logic [15:0] exp_cnt1 = 16'd0;
  bit          exp_err  = 1'b0;
  logic        cur_sel  = 1'b0;
  bit          other_seen = 1'b0;

  split_4ph #(.WIDTH(WIDTH), .FL(FL), .BL(BL)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_req(d_req), .d_ack(d_ack), .d_data(d_data),
    .s_req(s_req), .s_ack(s_ack), .s_sel(s_sel),
    .o0_req(o0_req), .o0_ack(o0_ack), .o0_data(o0_data),
    .o1_req(o1_req), .o1_ack(o1_ack), .o1_data(o1_data),
    .count0(count0), .count1(count1), .proto_err(proto_err)
  );

  // Same stimulus, counters start one token short of wrapping.
  split_4ph #(.WIDTH(WIDTH), .FL(FL), .BL(BL), .COUNT_INIT(16'hFFFF)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .d_req(d_req), .d_ack(w_d_ack), .d_data(d_data),
    .s_req(s_req), .s_ack(w_s_ack), .s_sel(s_sel),
    .o0_req(w_o0_req), .o0_ack(o0_ack), .o0_data(w_o0_data),
    .o1_req(w_o1_req), .o1_ack(o1_ack), .o1_data(w_o1_data),
    .count0(w_count0), .count1(w_count1), .proto_err(w_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The unselected output must never request.
  always @(negedge clk) if ((cur_sel ? o0_req : o1_req) === 1'b1) other_seen = 1'b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel_req(input logic sel);
    return sel ? o1_req : o0_req;
  endfunction

  // mode 0: normal, 1: drop d_req in OREQ, 2: reset in BWD (returns after reset release)
  task automatic run_token(input logic [WIDTH-1:0] data, input logic sel, input int dly,
                           input int mode, output int k_cap);
    int  k, m;
    bit  got;
    cur_sel    = sel;
    other_seen = 1'b0;
    d_data = data; s_sel = sel; d_req = 1'b1; s_req = 1'b1;
    tick();
    k = cyc;
    k_cap = k;
    got = 1'b0;
    for (int t = 0; t < BUDGET && !got; t++) begin
      if (sel_req(sel) === 1'b1) got = 1'b1;
      else tick();
    end
    if (!got) begin chk("req_timeout", 0, 1); return; end
    chk("fl_latency", cyc - k, FL);
    chk("o_data", sel ? o1_data : o0_data, data);
    if (mode == 1) begin d_req = 1'b0; exp_err = 1'b1; end
    repeat (dly) tick();
    if (sel) o1_ack = 1'b1; else o0_ack = 1'b1;
    tick();
    m = cyc;
    chk("oreq_drop", sel_req(sel), 0);
    o0_ack = 1'b0; o1_ack = 1'b0;
    if (mode == 2) begin
      tick();
      rst_n = 1'b0;
      #1;
      chk("rst_outputs", {d_ack, s_ack, o0_req, o1_req, proto_err}, 0);
      chk("rst_data", o0_data | o1_data, 0);
      chk("rst_counts", {count0, count1}, 0);
      exp_cnt0 = 16'd0; exp_cnt1 = 16'd0; exp_err = 1'b0;
      #2;
      rst_n = 1'b1;
      return;
    end
    got = 1'b0;
    for (int t = 0; t < BUDGET && !got; t++) begin
      if (d_ack === 1'b1) got = 1'b1;
      else tick();
    end
    if (!got) begin chk("dack_timeout", 0, 1); return; end
    chk("bl_latency", cyc - m, BL);
    chk("s_ack_with_d_ack", s_ack, 1);
    d_req = 1'b0; s_req = 1'b0;
    tick();
    chk("ack_rtz", {d_ack, s_ack}, 0);
    if (sel) exp_cnt1 = exp_cnt1 + 16'd1;
    else     exp_cnt0 = exp_cnt0 + 16'd1;
    chk("count0", count0, exp_cnt0);
    chk("count1", count1, exp_cnt1);
    chk("proto_err", proto_err, exp_err);
    chk("unselected_req", other_seen, 0);
  endtask

  initial begin
    int          k, prev_k, prev_dly, dly;
    logic        sel;
    bit          busy;
    logic [16:0] sum0;
    d_req = 1'b0; s_req = 1'b0; s_sel = 1'b0; d_data = '0;
    o0_ack = 1'b0; o1_ack = 1'b0; rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {d_ack, s_ack, o0_req, o1_req, proto_err}, 0);
    chk("reset_data", o0_data | o1_data, 0);
    chk("reset_counts", {count0, count1}, 0);
    rst_n = 1'b1;
    tick();

    // Directed token to O0.
    run_token(33'h1A2B3C4D5, 1'b0, 0, 0, k);

    // d_req alone must not capture nor flag an error.
    d_data = 33'h0_0000_0055; s_sel = 1'b1; d_req = 1'b1; s_req = 1'b0;
    busy = 1'b0;
    repeat (20) begin
      tick();
      busy = busy | o0_req | o1_req | d_ack | s_ack;
    end
    chk("wait_no_capture", busy, 0);
    chk("wait_no_err", proto_err, 0);
    run_token(33'h0_0000_0055, 1'b1, 0, 0, k);

    // Twelve random back-to-back tokens.
    sum0 = 17'(count0) + 17'(count1);
    prev_k = 0; prev_dly = 0;
    for (int i = 0; i < 12; i++) begin
      sel = 1'($urandom_range(0, 1));
      dly = (i == 0) ? 0 : int'($urandom_range(0, 3));
      run_token(WIDTH'($urandom % 64), sel, dly, 0, k);
      if (i > 0) chk("token_period", k - prev_k, FL + BL + 3 + prev_dly);
      prev_k = k; prev_dly = dly;
    end
    chk("twelve_tokens", (17'(count0) + 17'(count1)) - sum0, 12);

    // Protocol violation: d_req dropped while the output request is up.
    run_token({1'b1, $urandom}, 1'($urandom_range(0, 1)), 1, 1, k);
    tick();
    chk("proto_err_sticky", proto_err, 1);

    // Reset during BWD, requests held, then a fresh capture on the first edge.
    run_token(33'h1_0F0F_0F0F, 1'b1, 0, 2, k);
    run_token(33'h1_0F0F_0F0F, 1'b1, 0, 0, k);

    // Wrap of the O1 counter from 0xFFFF.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_cnt0 = 16'd0; exp_cnt1 = 16'd0; exp_err = 1'b0;
    tick();
    chk("wrap_preload", w_count1, 16'hFFFF);
    run_token({$urandom, 1'b0}, 1'b1, 0, 0, k);
    chk("wrap_count1", w_count1, 16'h0000);
    chk("wrap_proto_err", w_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
